// File: rtl/adc_rx_pkg.sv
// Shared definitions for the multi-lane serial ADC receiver: FSM encoding and gap counter width.
package adc_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2,
    ST_GAP   = 2'd3
  } rx_state_t;

  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/adc_serial_rx_if.sv
// Control, serial-lane and valid/ready output bundle of adc_serial_rx.
// master = receiver side, slave = ADC/consumer side.
interface adc_serial_rx_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 1
);

  logic                     start_recording;
  logic                     continuous;
  logic [NUM_CH-1:0]        sdo;
  logic                     cs_n;
  logic [NUM_CH*DATA_W-1:0] data_adc;
  logic                     data_valid;
  logic                     data_ready;
  logic                     busy;
  logic                     overrun;
  logic [15:0]              drop_cnt;

  modport master (
    input  start_recording, continuous, sdo, data_ready,
    output cs_n, data_adc, data_valid, busy, overrun, drop_cnt
  );

  modport slave (
    output start_recording, continuous, sdo, data_ready,
    input  cs_n, data_adc, data_valid, busy, overrun, drop_cnt
  );

endinterface

// File: rtl/adc_rx_lane.sv
// One sdo lane: DATA_W-bit shift register, bit order chosen by MSB_FIRST.
module adc_rx_lane #(
  parameter int DATA_W    = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk105,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clear,
  input  logic              sdo,
  output logic [DATA_W-1:0] word
);

  // MSB-first enters at bit 0 and walks up; LSB-first enters at the top and walks down.
  always_ff @(negedge clk105 or posedge reset) begin
    if (reset) begin
      word <= '0;
    end else if (clear) begin
      word <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST != 0) begin
        word <= {word[DATA_W-2:0], sdo};
      end else begin
        word <= {sdo, word[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: rtl/adc_serial_rx.sv
// Multi-lane serial ADC receiver: framing FSM, counters and valid/ready output on falling clk105 edges.
// Optional macro ADC_SERIAL_RX_OVERRUN_EN enables the sticky overrun flag and dropped-word counter.
module adc_serial_rx
  import adc_rx_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int NUM_CH     = 1,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic            clk105,
  input  logic            reset,
  adc_serial_rx_if.master bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  rx_state_t                state;
  rx_state_t                next_state;
  logic [CNT_W-1:0]         bit_cnt;
  logic [GAP_CNT_W-1:0]     gap_cnt;
  logic                     shift_en;
  logic                     clear;
  logic                     load;
  logic [NUM_CH*DATA_W-1:0] shift_word;
  logic [NUM_CH*DATA_W-1:0] data_q;
  logic                     valid_q;

  always_ff @(negedge clk105 or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    shift_en   = 1'b0;
    clear      = 1'b0;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        clear = 1'b1;
        if (bus.start_recording) begin
          next_state = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (bit_cnt == LAST_BIT) begin
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        load = 1'b1;
        if (bus.continuous && bus.start_recording) begin
          next_state = (GAP_CYCLES > 0) ? ST_GAP : ST_SHIFT;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          next_state = bus.start_recording ? ST_SHIFT : ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk105 or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (state == ST_SHIFT && bit_cnt != LAST_BIT) begin
        bit_cnt <= bit_cnt + 1'b1;
      end else begin
        bit_cnt <= '0;
      end
      if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  // A load always wins over acceptance, so a word accepted on the load edge leaves valid high.
  always_ff @(negedge clk105 or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      data_q  <= shift_word;
      valid_q <= 1'b1;
    end else if (valid_q && bus.data_ready) begin
      valid_q <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    adc_rx_lane #(
      .DATA_W    (DATA_W),
      .MSB_FIRST (MSB_FIRST)
    ) u_lane (
      .clk105   (clk105),
      .reset    (reset),
      .shift_en (shift_en),
      .clear    (clear),
      .sdo      (bus.sdo[k]),
      .word     (shift_word[k*DATA_W +: DATA_W])
    );
  end

  assign bus.cs_n       = (state != ST_SHIFT);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.data_adc   = data_q;
  assign bus.data_valid = valid_q;

`ifdef ADC_SERIAL_RX_OVERRUN_EN
  logic        overrun_event;
  logic        overrun_q;
  logic [15:0] drop_q;

  assign overrun_event = load && valid_q && !bus.data_ready;

  always_ff @(negedge clk105 or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
      drop_q    <= '0;
    end else if (overrun_event) begin
      overrun_q <= 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign bus.overrun  = overrun_q;
  assign bus.drop_cnt = drop_q;
`else
  assign bus.overrun  = 1'b0;
  assign bus.drop_cnt = '0;
`endif

endmodule

// File: tb/tb_adc_serial_rx.sv
// Bench for adc_serial_rx: an MSB-first 4-lane instance with gap 2 and an LSB-first instance,
// fed by a small ADC model that shifts out queued bits while cs_n is low.
module tb_adc_serial_rx;

  localparam int DW  = 16;
  localparam int NC  = 4;
  localparam int GAP = 2;
  localparam int TW  = NC * DW;
`ifdef ADC_SERIAL_RX_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic clk105 = 1'b0;
  logic reset  = 1'b0;
  always #5 clk105 = ~clk105;

  adc_serial_rx_if #(.DATA_W(DW), .NUM_CH(NC)) bus_m ();
  adc_serial_rx_if #(.DATA_W(DW), .NUM_CH(NC)) bus_l ();

  adc_serial_rx #(.DATA_W(DW), .NUM_CH(NC), .MSB_FIRST(1), .GAP_CYCLES(GAP)) dut_m (
    .clk105 (clk105),
    .reset  (reset),
    .bus    (bus_m.master)
  );

  adc_serial_rx #(.DATA_W(DW), .NUM_CH(NC), .MSB_FIRST(0), .GAP_CYCLES(0)) dut_l (
    .clk105 (clk105),
    .reset  (reset),
    .bus    (bus_l.master)
  );

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  int low_cnt = 0;
  int hi_run = 0;
  bit in_word = 1'b0;
  logic [NC-1:0] bitq_m[$];
  logic [NC-1:0] bitq_l[$];
  logic [TW-1:0] got_q[$];
  int            got_t[$];
  int            hi_runs[$];

  // Record a transfer decided on the coming falling edge, then advance to the rising edge
  // where the ADC model shifts out the next bit of every lane whose cs_n is low.
  task automatic tick();
    if (bus_m.data_valid === 1'b1 && bus_m.data_ready === 1'b1) begin
      got_q.push_back(bus_m.data_adc);
      got_t.push_back(edge_cnt);
    end
    @(posedge clk105);
    edge_cnt++;
    if (bus_m.cs_n === 1'b0) begin
      low_cnt++;
      if (in_word && hi_run > 0) hi_runs.push_back(hi_run);
      in_word = 1'b1;
      hi_run  = 0;
      if (bitq_m.size() > 0) bus_m.sdo = bitq_m.pop_front();
      else bus_m.sdo = NC'($urandom);
    end else begin
      hi_run++;
    end
    if (bus_l.cs_n === 1'b0) begin
      if (bitq_l.size() > 0) bus_l.sdo = bitq_l.pop_front();
      else bus_l.sdo = NC'($urandom);
    end
  endtask

  // Reference: bit i of a lane's time sequence lands at position DW-1-i (MSB first) or i.
  function automatic logic [TW-1:0] model_word(input logic [NC-1:0] seq[DW], input bit msb);
    logic [TW-1:0] w;
    int pos;
    w = '0;
    for (int i = 0; i < DW; i++) begin
      pos = msb ? (DW - 1 - i) : i;
      for (int k = 0; k < NC; k++) w[k*DW + pos] = seq[i][k];
    end
    return w;
  endfunction

  task automatic queue_random(input bit to_l, output logic [TW-1:0] expected);
    logic [NC-1:0] seq[DW];
    for (int i = 0; i < DW; i++) begin
      seq[i] = NC'($urandom);
      if (to_l) bitq_l.push_back(seq[i]);
      else bitq_m.push_back(seq[i]);
    end
    expected = model_word(seq, !to_l);
  endtask

  task automatic queue_values(input logic [DW-1:0] vals[NC], input bit to_l);
    logic [NC-1:0] v;
    for (int i = 0; i < DW; i++) begin
      for (int k = 0; k < NC; k++) v[k] = to_l ? vals[k][i] : vals[k][DW-1-i];
      if (to_l) bitq_l.push_back(v);
      else bitq_m.push_back(v);
    end
  endtask

  task automatic drain();
    bus_m.data_ready = 1'b1;
    bus_l.data_ready = 1'b1;
    tick();
    bus_m.data_ready = 1'b0;
    bus_l.data_ready = 1'b0;
    bus_m.start_recording = 1'b0;
    bus_l.start_recording = 1'b0;
    repeat (3) tick();
    got_q.delete();
    got_t.delete();
    bitq_m.delete();
    bitq_l.delete();
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    repeat (3) tick();
    checks += 7;
    if (bus_m.cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_cs_n got %b want 1", bus_m.cs_n); end
    if (bus_m.data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b want 0", bus_m.data_valid); end
    if (bus_m.data_adc !== '0) begin errors++; $display("[TB] FAIL reset_data got %h want 0", bus_m.data_adc); end
    if (bus_m.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus_m.busy); end
    if (bus_m.overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun got %b want 0", bus_m.overrun); end
    if (bus_l.cs_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_l_cs_n got %b want 1", bus_l.cs_n); end
    if (bus_l.data_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_l_valid got %b want 0", bus_l.data_valid); end
    #1 reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus_m.busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy got %b want 0", bus_m.busy); end
  endtask

  task automatic test_single_shot();
    logic [DW-1:0] vals[NC];
    int n;
    logic [TW-1:0] held;
    vals = '{16'hA5C3, 16'h0F0F, 16'hFFFF, 16'h0000};
    queue_values(vals, 1'b0);
    low_cnt = 0;
    bus_m.continuous = 1'b0;
    bus_m.start_recording = 1'b1;
    tick();
    bus_m.start_recording = 1'b0;
    n = 1;
    while (bus_m.data_valid !== 1'b1 && n < 40) begin tick(); n++; end
    checks += 4;
    if (n != DW + 2) begin errors++; $display("[TB] FAIL single_latency got %0d want %0d", n, DW + 2); end
    if (low_cnt != DW) begin errors++; $display("[TB] FAIL single_cs_low got %0d want %0d", low_cnt, DW); end
    if (bus_m.data_adc !== 64'h0000_FFFF_0F0F_A5C3) begin errors++; $display("[TB] FAIL single_data got %h want 0000ffff0f0fa5c3", bus_m.data_adc); end
    if (bus_m.busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy got %b want 0", bus_m.busy); end
    held = bus_m.data_adc;
    repeat (3) tick();
    checks += 2;
    if (bus_m.data_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid got %b want 1", bus_m.data_valid); end
    if (bus_m.data_adc !== held) begin errors++; $display("[TB] FAIL hold_data got %h want %h", bus_m.data_adc, held); end
    bus_m.data_ready = 1'b1;
    tick();
    bus_m.data_ready = 1'b0;
    checks++;
    if (bus_m.data_valid !== 1'b0) begin errors++; $display("[TB] FAIL accept_valid got %b want 0", bus_m.data_valid); end
    drain();
  endtask

  task automatic test_lane_order();
    logic [DW-1:0] vals[NC];
    logic [TW-1:0] exp_m;
    logic [TW-1:0] exp_l;
    int n;
    for (int it = 0; it < 4; it++) begin
      queue_random(1'b0, exp_m);
      if (it == 0) begin
        vals = '{16'h0001, 16'h8000, 16'hFFFF, 16'h1234};
        queue_values(vals, 1'b1);
        exp_l = 64'h1234_FFFF_8000_0001;
      end else begin
        queue_random(1'b1, exp_l);
      end
      bus_m.start_recording = 1'b1;
      bus_l.start_recording = 1'b1;
      tick();
      bus_m.start_recording = 1'b0;
      bus_l.start_recording = 1'b0;
      n = 1;
      while (bus_m.data_valid !== 1'b1 && n < 40) begin tick(); n++; end
      checks += 3;
      if (bus_m.data_adc !== exp_m) begin errors++; $display("[TB] FAIL lane_msb_%0d got %h want %h", it, bus_m.data_adc, exp_m); end
      if (bus_l.data_adc !== exp_l) begin errors++; $display("[TB] FAIL lane_lsb_%0d got %h want %h", it, bus_l.data_adc, exp_l); end
      if (bus_l.data_valid !== 1'b1) begin errors++; $display("[TB] FAIL lane_lsb_valid_%0d got %b want 1", it, bus_l.data_valid); end
      drain();
    end
  endtask

  task automatic test_continuous();
    logic [DW-1:0] vals[NC];
    logic [TW-1:0] exp_q[$];
    logic [TW-1:0] w;
    logic [DW-1:0] base;
    int n;
    bit dropped;
    hi_runs.delete();
    in_word = 1'b0;
    hi_run = 0;
    for (int j = 0; j < 3; j++) begin
      base = DW'(16'h1111 * (j + 1));
      for (int k = 0; k < NC; k++) begin
        vals[k] = base + DW'(k);
        w[k*DW +: DW] = base + DW'(k);
      end
      queue_values(vals, 1'b0);
      exp_q.push_back(w);
    end
    bus_m.data_ready = 1'b1;
    bus_m.continuous = 1'b1;
    bus_m.start_recording = 1'b1;
    n = 0;
    dropped = 1'b0;
    while (got_q.size() < 3 && n < 150) begin
      tick();
      n++;
      if (!dropped && got_q.size() >= 2 && bus_m.cs_n === 1'b0) begin
        bus_m.start_recording = 1'b0;
        dropped = 1'b1;
      end
    end
    repeat (3) tick();
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("[TB] FAIL cont_count got %0d want 3", got_q.size());
    end else begin
      for (int j = 0; j < 3; j++) begin
        checks++;
        if (got_q[j] !== exp_q[j]) begin errors++; $display("[TB] FAIL cont_word_%0d got %h want %h", j, got_q[j], exp_q[j]); end
      end
      for (int j = 1; j < 3; j++) begin
        checks++;
        if (got_t[j] - got_t[j-1] != DW + 1 + GAP) begin
          errors++;
          $display("[TB] FAIL cont_period_%0d got %0d want %0d", j, got_t[j] - got_t[j-1], DW + 1 + GAP);
        end
      end
    end
    checks++;
    if (hi_runs.size() != 2) begin
      errors++;
      $display("[TB] FAIL cont_gap_count got %0d want 2", hi_runs.size());
    end else begin
      // cs_n is high for the load edge plus the programmed gap edges
      foreach (hi_runs[j]) begin
        checks++;
        if (hi_runs[j] != GAP + 1) begin errors++; $display("[TB] FAIL cont_cs_high_%0d got %0d want %0d", j, hi_runs[j], GAP + 1); end
      end
    end
    checks++;
    if (bus_m.busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_end_busy got %b want 0", bus_m.busy); end
    bus_m.continuous = 1'b0;
    drain();
  endtask

  task automatic test_overrun();
    logic [DW-1:0] vals[NC];
    logic [TW-1:0] exp2;
    int n;
    bit dropped;
    for (int k = 0; k < NC; k++) vals[k] = 16'hAAAA + DW'(k);
    queue_values(vals, 1'b0);
    for (int k = 0; k < NC; k++) begin
      vals[k] = 16'h5555 + DW'(k);
      exp2[k*DW +: DW] = 16'h5555 + DW'(k);
    end
    queue_values(vals, 1'b0);
    bus_m.data_ready = 1'b0;
    bus_m.continuous = 1'b1;
    bus_m.start_recording = 1'b1;
    n = 0;
    dropped = 1'b0;
    while (n < 100 && !(dropped && bus_m.busy === 1'b0)) begin
      tick();
      n++;
      if (!dropped && bus_m.data_valid === 1'b1 && bus_m.cs_n === 1'b0) begin
        bus_m.start_recording = 1'b0;
        dropped = 1'b1;
      end
    end
    checks += 6;
    if (n >= 100) begin errors++; $display("[TB] FAIL ovr_timeout got %0d edges want <100", n); end
    if (bus_m.data_adc !== exp2) begin errors++; $display("[TB] FAIL ovr_data got %h want %h", bus_m.data_adc, exp2); end
    if (bus_m.data_valid !== 1'b1) begin errors++; $display("[TB] FAIL ovr_valid got %b want 1", bus_m.data_valid); end
    if (bus_m.overrun !== OVR_EN) begin errors++; $display("[TB] FAIL ovr_flag got %b want %b", bus_m.overrun, OVR_EN); end
    if (bus_m.drop_cnt !== (OVR_EN ? 16'd1 : 16'd0)) begin errors++; $display("[TB] FAIL ovr_drop_cnt got %0d want %0d", bus_m.drop_cnt, OVR_EN); end
    if (got_q.size() != 0) begin errors++; $display("[TB] FAIL ovr_no_transfer got %0d want 0", got_q.size()); end
    bus_m.continuous = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_word();
    logic [TW-1:0] junk;
    logic [TW-1:0] exp_b;
    int n;
    queue_random(1'b0, junk);
    low_cnt = 0;
    bus_m.continuous = 1'b0;
    bus_m.start_recording = 1'b1;
    n = 0;
    while (low_cnt < 8 && n < 40) begin tick(); n++; end
    #2 reset = 1'b1;
    #1;
    checks += 5;
    if (bus_m.cs_n !== 1'b1) begin errors++; $display("[TB] FAIL midrst_cs_n got %b want 1", bus_m.cs_n); end
    if (bus_m.busy !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy got %b want 0", bus_m.busy); end
    if (bus_m.data_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_valid got %b want 0", bus_m.data_valid); end
    if (bus_m.data_adc !== '0) begin errors++; $display("[TB] FAIL midrst_data got %h want 0", bus_m.data_adc); end
    if (bus_m.overrun !== 1'b0) begin errors++; $display("[TB] FAIL midrst_overrun got %b want 0", bus_m.overrun); end
    #1 reset = 1'b0;
    bitq_m.delete();
    queue_random(1'b0, exp_b);
    tick();
    bus_m.start_recording = 1'b0;
    n = 1;
    while (bus_m.data_valid !== 1'b1 && n < 40) begin tick(); n++; end
    checks += 2;
    if (n != DW + 2) begin errors++; $display("[TB] FAIL midrst_latency got %0d want %0d", n, DW + 2); end
    if (bus_m.data_adc !== exp_b) begin errors++; $display("[TB] FAIL midrst_data_after got %h want %h", bus_m.data_adc, exp_b); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] exp1;
    logic [TW-1:0] exp2;
    int n;
    bit dropped;
    bit armed;
    queue_random(1'b0, exp1);
    queue_random(1'b0, exp2);
    low_cnt = 0;
    bus_m.data_ready = 1'b0;
    bus_m.continuous = 1'b1;
    bus_m.start_recording = 1'b1;
    n = 0;
    dropped = 1'b0;
    armed = 1'b0;
    while (!armed && n < 100) begin
      tick();
      n++;
      if (!dropped && bus_m.data_valid === 1'b1 && bus_m.cs_n === 1'b0) begin
        bus_m.start_recording = 1'b0;
        dropped = 1'b1;
      end
      // second word fully shifted; the next falling edge both loads it and accepts the first
      if (low_cnt == 2 * DW && bus_m.cs_n === 1'b1) begin
        checks++;
        if (bus_m.data_adc !== exp1) begin errors++; $display("[TB] FAIL b2b_first got %h want %h", bus_m.data_adc, exp1); end
        bus_m.data_ready = 1'b1;
        tick();
        bus_m.data_ready = 1'b0;
        armed = 1'b1;
      end
    end
    checks += 5;
    if (!armed) begin errors++; $display("[TB] FAIL b2b_timeout got %0d edges want <100", n); end
    if (bus_m.data_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid got %b want 1", bus_m.data_valid); end
    if (bus_m.data_adc !== exp2) begin errors++; $display("[TB] FAIL b2b_second got %h want %h", bus_m.data_adc, exp2); end
    if (got_q.size() != 1) begin errors++; $display("[TB] FAIL b2b_transfers got %0d want 1", got_q.size()); end
    if (bus_m.overrun !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overrun got %b want 0", bus_m.overrun); end
    bus_m.continuous = 1'b0;
    drain();
  endtask

  task automatic test_abort_mid_word();
    logic [TW-1:0] expected;
    int n;
    queue_random(1'b0, expected);
    low_cnt = 0;
    bus_m.data_ready = 1'b0;
    bus_m.continuous = 1'b1;
    bus_m.start_recording = 1'b1;
    n = 0;
    while (bus_m.data_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
      if (low_cnt == 4) bus_m.start_recording = 1'b0;
    end
    checks += 4;
    if (n != DW + 2) begin errors++; $display("[TB] FAIL abort_latency got %0d want %0d", n, DW + 2); end
    if (bus_m.data_adc !== expected) begin errors++; $display("[TB] FAIL abort_data got %h want %h", bus_m.data_adc, expected); end
    if (bus_m.busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", bus_m.busy); end
    if (bus_m.cs_n !== 1'b1) begin errors++; $display("[TB] FAIL abort_cs_n got %b want 1", bus_m.cs_n); end
    repeat (25) tick();
    checks++;
    if (low_cnt != DW) begin errors++; $display("[TB] FAIL abort_no_restart got %0d low edges want %0d", low_cnt, DW); end
    bus_m.continuous = 1'b0;
    drain();
  endtask

  initial begin
    bus_m.start_recording = 1'b0;
    bus_m.continuous      = 1'b0;
    bus_m.sdo             = '0;
    bus_m.data_ready      = 1'b0;
    bus_l.start_recording = 1'b0;
    bus_l.continuous      = 1'b0;
    bus_l.sdo             = '0;
    bus_l.data_ready      = 1'b0;
    $display("[TB] adc_serial_rx bench start");
    test_reset();
    test_single_shot();
    test_lane_order();
    test_continuous();
    test_overrun();
    test_reset_mid_word();
    test_back_to_back();
    test_abort_mid_word();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
